// File: rtl/risc_spm_pkg.sv
// Shared defaults and dump FSM state encoding for the RISC SPM memory dump path.
// The CSUM state exists only when DUMP_CHECKSUM_EN is defined.
package risc_spm_pkg;

    localparam int unsigned WORD_SIZE_DFLT = 8;
    localparam int unsigned ADDR_SIZE_DFLT = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
`ifdef DUMP_CHECKSUM_EN
        CSUM = 3'd4,
`endif
        DONE = 3'd5
    } dump_state_e;

endpackage

// File: rtl/mem_dump_unit.sv
// Streams a range of SRAM words out over a valid/ready byte interface.
// Optional trailing two's-complement checksum byte when DUMP_CHECKSUM_EN is defined.
module mem_dump_unit
    import risc_spm_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DFLT,
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [ADDR_SIZE:0]   count,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    dump_state_e          state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
    logic [WORD_SIZE-1:0] csum_q, csum_d;
`endif

    // Next-state and datapath; outputs are registered copies derived from state_d.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = start_addr;
                    rem_d  = count;
`ifdef DUMP_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (count != '0) begin
                        state_d = READ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        data_d  = '0;
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                data_d  = mem_rdata;
`ifdef DUMP_CHECKSUM_EN
                csum_d  = csum_q + mem_rdata;
`endif
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    addr_d = addr_q + ADDR_SIZE'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q != CNT_W'(1)) begin
                        state_d = READ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        // Negated sum so data bytes plus this byte total zero.
                        data_d  = {WORD_SIZE{1'b0}} - csum_q;
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (out_ready) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d    = (state_d == READ);
`ifdef DUMP_CHECKSUM_EN
        valid_d = (state_d == SEND) || (state_d == CSUM);
`else
        valid_d = (state_d == SEND);
`endif
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Scoreboard bench for mem_dump_unit: directed dumps, wrap, stall, ignored start, count=0, reset abort.
module tb_mem_dump_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] count;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int done0;
    logic prev_done = 1'b0;
    logic [7:0] exp_q [$];
    int addr_log [$];

    mem_dump_unit #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM model: data valid the cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte act=%0h exp=none t=%0t", out_data, $time);
                end else begin
                    check("byte", out_data, exp_q.pop_front());
                end
            end
            if (mem_rd) addr_log.push_back(int'(mem_addr));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_width", prev_done, 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_dump(input logic [7:0] a, input logic [8:0] c);
        @(posedge clk);
        #2;
        start = 1'b1;
        start_addr = a;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout act=busy exp=idle t=%0t", $time);
        end
        @(negedge clk);
    endtask

    task automatic push_a();
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(8'hF7);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic found;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[128] = 8'h06; mem[129] = 8'h01; mem[130] = 8'h02; mem[131] = 8'h00;
        mem[255] = 8'hF0; mem[0] = 8'h00;
        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Basic dump with latency probes
        push_a();
        addr_log.delete();
        done0 = done_cnt;
        start_dump(8'd128, 9'd4);
        check("a_rd_T1", mem_rd, 1);
        check("a_addr_T1", mem_addr, 128);
        check("a_busy", busy, 1);
        @(posedge clk); #1;
        check("a_valid_T2", out_valid, 0);
        check("a_rd_T2", mem_rd, 0);
        @(posedge clk); #1;
        check("a_valid_T3", out_valid, 1);
        check("a_data_T3", out_data, 8'h06);
        wait_idle(100);
        check("a_left", exp_q.size(), 0);
        check("a_done_cnt", done_cnt - done0, 1);
        check("a_done_lat", done_cyc - last_hs_cyc, 1);
        check("a_nreads", addr_log.size(), 4);
        check("a_last_addr", addr_log[3], 131);

        // Address wrap 255 -> 0
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h00);
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(8'h10);
`endif
        addr_log.delete();
        start_dump(8'd255, 9'd2);
        wait_idle(100);
        check("b_nreads", addr_log.size(), 2);
        check("b_addr0", addr_log[0], 255);
        check("b_addr1", addr_log[1], 0);
        check("b_left", exp_q.size(), 0);

        // Back-pressure on the first byte
        push_a();
        addr_log.delete();
        out_ready = 1'b0;
        start_dump(8'd128, 9'd4);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("c_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("c_hold_valid", out_valid, 1);
            check("c_hold_data", out_data, 8'h06);
            check("c_hold_rd", mem_rd, 0);
        end
        check("c_stall_reads", addr_log.size(), 1);
        out_ready = 1'b1;
        wait_idle(100);
        check("c_left", exp_q.size(), 0);
        check("c_nreads", addr_log.size(), 4);

        // Second start while busy is ignored
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h01);
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(8'hF9);
`endif
        addr_log.delete();
        start_dump(8'd128, 9'd2);
        @(posedge clk); #2;
        start = 1'b1; start_addr = 8'd0; count = 9'd5;
        @(posedge clk); #2;
        start = 1'b0;
        wait_idle(100);
        check("d_nreads", addr_log.size(), 2);
        check("d_addr1", addr_log[1], 129);
        check("d_left", exp_q.size(), 0);

        // count = 0
        done0 = done_cnt;
        addr_log.delete();
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(8'h00);
`endif
        start_dump(8'd0, 9'd0);
`ifndef DUMP_CHECKSUM_EN
        check("z_done_T1", done, 1);
        check("z_valid", out_valid, 0);
`endif
        check("z_rd", mem_rd, 0);
        wait_idle(50);
        check("z_done_cnt", done_cnt - done0, 1);
        check("z_left", exp_q.size(), 0);
        check("z_nreads", addr_log.size(), 0);

        // Reset during SEND of the second byte
        push_a();
        hs_cnt = 0;
        done0 = done_cnt;
        start_dump(8'd128, 9'd4);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #2;
            if (hs_cnt == 1 && out_valid) found = 1'b1;
        end
        check("e_second_send", found, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("e_valid", out_valid, 0);
        check("e_data", out_data, 0);
        check("e_rd", mem_rd, 0);
        check("e_addr", mem_addr, 0);
        check("e_busy", busy, 0);
        check("e_done", done, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        check("e_no_done", done_cnt - done0, 0);
        push_a();
        start_dump(8'd128, 9'd4);
        wait_idle(100);
        check("e_restart_left", exp_q.size(), 0);
        check("e_restart_done", done_cnt - done0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
